pixel_stream_parser: RTL and testbench
======================================

PIXEL_STREAM_PARSER -- requirements
Module: pixel_stream_parser

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CHANNELS, 3: bytes per pixel (1..4).
- DIM_W, 8: height/width width (8 or 16); sent MSB-first as DIM_W/8 bytes.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYC, 100000: idle cycles mid-frame before abort.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-low reset.
- rx_data, in, 8: received UART byte.
- rx_valid, in, 1: one-cycle strobe, rx_data valid; no backpressure.
- pix_data, out, CHANNELS*8: pixel; channel 0 in bits [7:0] = first byte received.
- pix_valid, out, 1: pixel available.
- pix_ready, in, 1: consumer accepts; transfer when pix_valid && pix_ready.
- pix_x, out, DIM_W: column of the pixel on pix_data.
- pix_y, out, DIM_W: row of the pixel on pix_data.
- height, out, DIM_W: latched frame height.
- width, out, DIM_W: latched frame width.
- busy, out, 1: high in any state other than IDLE.
- frame_done, out, 1: one-cycle pulse, good checksum.
- frame_err, out, 1: one-cycle pulse, frame aborted.

Function
REQ-003 FSM states SHALL be IDLE, HDR_H, HDR_W, PIXEL, CHECK, DRAIN.
REQ-004 IDLE: byte == SYNC_BYTE -> HDR_H; all other bytes SHALL be discarded silently.
REQ-005 HDR_H and HDR_W SHALL each consume DIM_W/8 bytes, shift MSB-first into height/width, then advance.
REQ-006 If height or width == 0 at HDR_W completion, the block SHALL pulse frame_err and go to IDLE.
REQ-007 PIXEL: bytes SHALL assemble into a CHANNELS-byte register.
- On the CHANNELS-th byte, the assembled pixel SHALL load the output register the next cycle with pix_valid=1 and its x/y.
REQ-008 pix_data, pix_x, pix_y SHALL be held stable while pix_valid && !pix_ready; pix_valid SHALL clear the cycle after acceptance unless a new pixel loads that same cycle.
REQ-009 A pixel completing while the output register is still held SHALL cause overflow: frame_err pulse, pix_valid cleared, state IDLE.
REQ-010 pix_x SHALL count 0..width-1 and wrap to 0 with pix_y+1; after pixel (width-1, height-1) the state SHALL become CHECK.
REQ-011 A running 8-bit XOR SHALL cover all header dimension bytes and pixel bytes, excluding SYNC_BYTE.
REQ-012 CHECK: the next byte SHALL be compared with the XOR.
- Match: state DRAIN.
- Mismatch: frame_err pulse, state IDLE.
REQ-013 DRAIN: the block SHALL wait until pix_valid == 0, then pulse frame_done and return to IDLE; frame_done never precedes acceptance of the last pixel.
REQ-014 In any state other than IDLE/DRAIN, TIMEOUT_CYC consecutive cycles without rx_valid SHALL produce a frame_err pulse and return to IDLE; the counter SHALL reset on every rx_valid.
REQ-015 A SYNC_BYTE value inside header/pixel/checksum fields SHALL be treated as data, not a restart.
REQ-016 height/width SHALL hold their values until the next HDR_H entry, including after an error.
REQ-017 frame_err and frame_done SHALL never be asserted in the same cycle.

Reset
REQ-018 When reset is low, the block SHALL immediately clear all outputs and go to IDLE: pix_valid=0, pix_data=0, pix_x=0, pix_y=0, height=0, width=0, busy=0, frame_done=0, frame_err=0; XOR, counters and assembly register SHALL also clear.
REQ-019 Reset mid-frame SHALL discard partial data with no frame_err pulse.

Verification
REQ-020 The bench SHALL cover (CHANNELS=3, DIM_W=8; stimulus -> required response):
- Normal frame, pix_ready=1: A5 02 02, bytes 01..0C, checksum 0C -> four pixels 030201,060504,090807,0C0B0A at (0,0),(1,0),(0,1),(1,1); frame_done pulse; busy low afterwards.
- Bad checksum: same frame, trailer 00 -> four pixels, then frame_err pulse, no frame_done.
- Backpressure overflow: pix_ready=0 for the entire frame -> first pixel held stable; frame_err at completion of the 2nd pixel.
- Zero dimension: A5 00 05 -> frame_err after the width byte; height=0, width=5.
- Timeout (TIMEOUT_CYC=16): A5 02, then silence -> frame_err exactly 16 cycles after the last rx_valid.
- Reset: reset low for one cycle after 5 pixel bytes -> all outputs 0, no frame_err; a following full frame parses correctly.

Source files
------------

// File: rtl/pixel_stream_parser.sv
// Pixel stream parser: turns a UART byte stream (sync, height, width, pixel
// bytes, XOR checksum) into a valid/ready pixel stream with x/y coordinates.
module pixel_stream_parser #(
  parameter int         CHANNELS    = 3,
  parameter int         DIM_W       = 8,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [CHANNELS*8-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [DIM_W-1:0]      pix_x,
  output logic [DIM_W-1:0]      pix_y,
  output logic [DIM_W-1:0]      height,
  output logic [DIM_W-1:0]      width,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int               DIM_BYTES = DIM_W / 8;
  localparam int               TO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [1:0]       DIM_LAST  = 2'(DIM_BYTES - 1);
  localparam logic [1:0]       CH_LAST   = 2'(CHANNELS - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
  localparam logic [DIM_W-1:0] DIM_ONE   = DIM_W'(1);
  localparam logic [DIM_W-1:0] DIM_ZERO  = '0;

  typedef enum logic [2:0] {IDLE, HDR_H, HDR_W, PIXEL, CHECK, DRAIN} state_t;

  state_t                  state_q;
  logic [1:0]              cnt_q;
  logic [7:0]              xor_q;
  logic [CHANNELS*8-1:0]   asm_q;
  logic [DIM_W-1:0]        height_q, width_q;
  logic [DIM_W-1:0]        cur_x_q, cur_y_q;
  logic [TO_W-1:0]         idle_cnt_q;
  logic [CHANNELS*8-1:0]   pix_data_q;
  logic                    pix_valid_q;
  logic [DIM_W-1:0]        pix_x_q, pix_y_q;
  logic                    frame_done_q, frame_err_q;

  logic [DIM_W+7:0]        height_sh_s, width_sh_s;
  logic [DIM_W-1:0]        height_d, width_d;
  logic [CHANNELS*8-1:0]   asm_d;
  logic [7:0]              xor_d;
  logic                    x_last_s, y_last_s, timeout_s, out_held_s, timed_s;

  // Next values for the shift/assembly registers and frame-position flags.
  always_comb begin
    height_sh_s = {height_q, rx_data};
    width_sh_s  = {width_q, rx_data};
    height_d    = height_sh_s[DIM_W-1:0];
    width_d     = width_sh_s[DIM_W-1:0];
    asm_d       = asm_q;
    asm_d[{cnt_q, 3'b000} +: 8] = rx_data;
    xor_d       = xor_q ^ rx_data;
    x_last_s    = (cur_x_q == (width_q - DIM_ONE));
    y_last_s    = (cur_y_q == (height_q - DIM_ONE));
    out_held_s  = pix_valid_q && !pix_ready;
    timed_s     = (state_q != IDLE) && (state_q != DRAIN);
    timeout_s   = timed_s && !rx_valid && (idle_cnt_q == TO_LAST);
  end

  // Frame FSM with the datapath and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      xor_q        <= 8'h00;
      asm_q        <= '0;
      height_q     <= '0;
      width_q      <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      idle_cnt_q   <= '0;
      pix_data_q   <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (pix_valid_q && pix_ready) begin
        pix_valid_q <= 1'b0;
      end
      if (!timed_s || rx_valid) begin
        idle_cnt_q <= '0;
      end else begin
        idle_cnt_q <= idle_cnt_q + TO_ONE;
      end

      if (timeout_s) begin
        frame_err_q <= 1'b1;
        state_q     <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
              state_q  <= HDR_H;
              cnt_q    <= 2'd0;
              xor_q    <= 8'h00;
              height_q <= '0;
              width_q  <= '0;
              cur_x_q  <= '0;
              cur_y_q  <= '0;
            end
          end
          HDR_H: begin
            if (rx_valid) begin
              height_q <= height_d;
              xor_q    <= xor_d;
              if (cnt_q == DIM_LAST) begin
                cnt_q   <= 2'd0;
                state_q <= HDR_W;
              end else begin
                cnt_q <= cnt_q + 2'd1;
              end
            end
          end
          HDR_W: begin
            if (rx_valid) begin
              width_q <= width_d;
              xor_q   <= xor_d;
              if (cnt_q == DIM_LAST) begin
                cnt_q <= 2'd0;
                if ((height_q == DIM_ZERO) || (width_d == DIM_ZERO)) begin
                  frame_err_q <= 1'b1;
                  state_q     <= IDLE;
                end else begin
                  state_q <= PIXEL;
                end
              end else begin
                cnt_q <= cnt_q + 2'd1;
              end
            end
          end
          PIXEL: begin
            if (rx_valid) begin
              xor_q <= xor_d;
              asm_q <= asm_d;
              if (cnt_q == CH_LAST) begin
                cnt_q <= 2'd0;
                if (out_held_s) begin
                  // Consumer still holds the previous pixel: overflow.
                  frame_err_q <= 1'b1;
                  pix_valid_q <= 1'b0;
                  state_q     <= IDLE;
                end else begin
                  pix_data_q  <= asm_d;
                  pix_valid_q <= 1'b1;
                  pix_x_q     <= cur_x_q;
                  pix_y_q     <= cur_y_q;
                  if (x_last_s) begin
                    cur_x_q <= '0;
                    cur_y_q <= cur_y_q + DIM_ONE;
                    if (y_last_s) begin
                      state_q <= CHECK;
                    end
                  end else begin
                    cur_x_q <= cur_x_q + DIM_ONE;
                  end
                end
              end else begin
                cnt_q <= cnt_q + 2'd1;
              end
            end
          end
          CHECK: begin
            if (rx_valid) begin
              if (rx_data == xor_q) begin
                state_q <= DRAIN;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= IDLE;
              end
            end
          end
          DRAIN: begin
            // Only signal completion once the last pixel has left.
            if (!pix_valid_q) begin
              frame_done_q <= 1'b1;
              state_q      <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign height     = height_q;
  assign width      = width_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_pixel_stream_parser.sv
// Directed bench for pixel_stream_parser with a pixel scoreboard queue.
module tb_pixel_stream_parser;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        pix_ready = 1'b1;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic [7:0]  pix_x, pix_y, height, width;
  logic        busy, frame_done, frame_err;

  typedef struct packed {
    logic [23:0] d;
    logic [7:0]  x;
    logic [7:0]  y;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   d0, e0, n;

  always #5 clk = ~clk;

  pixel_stream_parser #(
    .CHANNELS(3), .DIM_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .height(height), .width(width),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_px(input logic [23:0] d, input logic [7:0] x, input logic [7:0] y);
    pix_t p;
    p.d = d; p.x = x; p.y = y;
    exp_q.push_back(p);
  endtask

  task automatic send_frame(input logic [7:0] trailer);
    push_px(24'h030201, 8'd0, 8'd0);
    push_px(24'h060504, 8'd1, 8'd0);
    push_px(24'h090807, 8'd0, 8'd1);
    push_px(24'h0C0B0A, 8'd1, 8'd1);
    send(8'hA5); send(8'h02); send(8'h02);
    for (int i = 1; i <= 12; i++) send(8'(i));
    send(trailer);
  endtask

  // Output monitor: pulse counting, pulse exclusivity and pixel scoreboard.
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
    if (frame_done || frame_err) chk("done_err_excl", {63'd0, frame_done & frame_err}, 64'd0);
    if (pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        chk("pix_unexpected", {24'd0, pix_data, pix_x, pix_y}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pix", {24'd0, pix_data, pix_x, pix_y}, {24'd0, mon_e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_pix", {39'd0, pix_valid, pix_data}, 64'd0);
    chk("rst_xy", {48'd0, pix_x, pix_y}, 64'd0);
    chk("rst_dim", {48'd0, height, width}, 64'd0);
    chk("rst_flags", {61'd0, busy, frame_done, frame_err}, 64'd0);
    reset = 1'b1;
    idle(2);

    // Normal frame
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h0C);
    idle(5);
    chk("norm_done", 64'(done_cnt - d0), 64'd1);
    chk("norm_err", 64'(err_cnt - e0), 64'd0);
    chk("norm_queue", 64'(exp_q.size()), 64'd0);
    chk("norm_busy", {63'd0, busy}, 64'd0);
    chk("norm_dim", {48'd0, height, width}, {48'd0, 8'd2, 8'd2});

    // Bad checksum
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h00);
    idle(5);
    chk("badck_err", 64'(err_cnt - e0), 64'd1);
    chk("badck_done", 64'(done_cnt - d0), 64'd0);
    chk("badck_queue", 64'(exp_q.size()), 64'd0);
    chk("badck_busy", {63'd0, busy}, 64'd0);

    // Backpressure overflow
    pix_ready = 1'b0;
    e0 = err_cnt;
    send(8'hA5); send(8'h02); send(8'h02);
    send(8'h01); send(8'h02); send(8'h03);
    chk("bp_valid", {63'd0, pix_valid}, 64'd1);
    chk("bp_first", {24'd0, pix_data, pix_x, pix_y}, {24'd0, 24'h030201, 8'd0, 8'd0});
    idle(3);
    send(8'h04); send(8'h05);
    chk("bp_hold", {23'd0, pix_valid, pix_data, pix_x, pix_y}, {23'd0, 1'b1, 24'h030201, 8'd0, 8'd0});
    send(8'h06);
    chk("bp_ovf_err", {63'd0, frame_err}, 64'd1);
    chk("bp_ovf_valid", {63'd0, pix_valid}, 64'd0);
    chk("bp_ovf_busy", {63'd0, busy}, 64'd0);
    pix_ready = 1'b1;
    idle(3);
    chk("bp_err_cnt", 64'(err_cnt - e0), 64'd1);

    // Zero dimension
    e0 = err_cnt;
    send(8'hA5); send(8'h00); send(8'h05);
    chk("zero_err", {63'd0, frame_err}, 64'd1);
    chk("zero_dim", {48'd0, height, width}, {48'd0, 8'd0, 8'd5});
    chk("zero_busy", {63'd0, busy}, 64'd0);
    idle(3);
    chk("zero_err_cnt", 64'(err_cnt - e0), 64'd1);

    // Timeout
    send(8'hA5); send(8'h02);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (frame_err) begin
        n = i;
        break;
      end
    end
    chk("timeout_cycles", 64'(n), 64'd16);
    chk("timeout_busy", {63'd0, busy}, 64'd0);
    chk("timeout_height", {56'd0, height}, {56'd0, 8'd2});
    idle(2);

    // Reset mid-frame
    push_px(24'h030201, 8'd0, 8'd0);
    send(8'hA5); send(8'h02); send(8'h02);
    for (int i = 1; i <= 5; i++) send(8'(i));
    e0 = err_cnt;
    reset = 1'b0;
    #1;
    chk("mrst_pix", {39'd0, pix_valid, pix_data}, 64'd0);
    chk("mrst_xy", {48'd0, pix_x, pix_y}, 64'd0);
    chk("mrst_dim", {48'd0, height, width}, 64'd0);
    chk("mrst_flags", {61'd0, busy, frame_done, frame_err}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);
    chk("mrst_no_err", 64'(err_cnt - e0), 64'd0);
    chk("mrst_queue", 64'(exp_q.size()), 64'd0);
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h0C);
    idle(5);
    chk("post_done", 64'(done_cnt - d0), 64'd1);
    chk("post_err", 64'(err_cnt - e0), 64'd0);
    chk("post_queue", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
